// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared FSM state encoding and register constants
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_hazard_detect.sv
// rtl/hazard_stall_unit_hazard_detect.sv - combinational stall-count (N) decode from register/control inputs
module hazard_detect
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs2,
  input  logic             ifid_branch,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_mem_read,
  output logic [1:0]       stall_n
);

  logic ex_rd_nz;
  logic mem_rd_nz;
  logic m_ex;
  logic m_mx;

  // Operand matches against EX and MEM destinations; x0 never creates a dependency
  always_comb begin
    ex_rd_nz  = (idex_rd != REG_W'(REG_ZERO));
    mem_rd_nz = (exmem_rd != REG_W'(REG_ZERO));
    m_ex = ex_rd_nz &&
           ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));
    m_mx = mem_rd_nz &&
           ((exmem_rd == ifid_rs1) || (ifid_use_rs2 && (exmem_rd == ifid_rs2)));
  end

  // A branch waiting on a load in EX needs the load to reach WB-forwardable MEM output: two bubbles
  always_comb begin
    stall_n = 2'd0;
    if (ifid_branch && idex_mem_read && m_ex) begin
      stall_n = 2'd2;
    end else if ((idex_mem_read && m_ex) ||
                 (ifid_branch && idex_reg_write && m_ex) ||
                 (ifid_branch && exmem_mem_read && m_mx)) begin
      stall_n = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush FSM with cache freeze and saturating stall-cycle counter
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_RS1,
  input  logic [REG_W-1:0] IFID_RS2,
  input  logic             IFID_UseRS2,
  input  logic             IFID_Branch,
  input  logic [REG_W-1:0] IDEX_RD,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [REG_W-1:0] EXMEM_RD,
  input  logic             EXMEM_MemRead,
  input  logic             BRANCH_Taken,
  input  logic             ICACHE_Stall,
  input  logic             DCACHE_Stall,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             PIPE_Hold,
  output logic [CNT_W-1:0] STALL_CNT
);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           act_state;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       stall_n;
  logic             cache;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .ifid_rs1      (IFID_RS1),
    .ifid_rs2      (IFID_RS2),
    .ifid_use_rs2  (IFID_UseRS2),
    .ifid_branch   (IFID_Branch),
    .idex_rd       (IDEX_RD),
    .idex_mem_read (IDEX_MemRead),
    .idex_reg_write(IDEX_RegWrite),
    .exmem_rd      (EXMEM_RD),
    .exmem_mem_read(EXMEM_MemRead),
    .stall_n       (stall_n)
  );

  assign cache = ICACHE_Stall || DCACHE_Stall;

  // Mealy next-state/output decode; leaving MEM_WAIT replays the saved state in the same cycle
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    act_state  = ((state_q == MEM_WAIT) && !cache) ? ret_q : state_q;

    case (act_state)
      RUN: begin
        if (cache) begin
          pipe_hold = 1'b1;
          ret_d     = RUN;
          state_d   = MEM_WAIT;
        end else if (stall_n != 2'd0) begin
          idex_flush = 1'b1;
          cnt_d      = stall_n - 2'd1;
          state_d    = (stall_n == 2'd2) ? STALL : RUN;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = BRANCH_Taken;
          state_d    = RUN;
        end
      end
      STALL: begin
        if (cache) begin
          pipe_hold = 1'b1;
          ret_d     = STALL;
          state_d   = MEM_WAIT;
        end else begin
          idex_flush = 1'b1;
          // The RUN cycle already supplied one bubble, so cnt counts the bubbles still owed
          cnt_d      = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          state_d    = (cnt_d == 2'd0) ? RUN : STALL;
        end
      end
      MEM_WAIT: begin
        pipe_hold = 1'b1;
        state_d   = MEM_WAIT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Count every cycle the PC is frozen, pinning at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, saved return state, bubble counter and performance counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset overrides the decode immediately: freeze fetch and kill both front-end stages
  assign PC_Write   = pc_write & ~rst;
  assign IFID_Write = ifid_write & ~rst;
  assign IFID_Flush = ifid_flush | rst;
  assign IDEX_Flush = idex_flush | rst;
  assign PIPE_Hold  = pipe_hold & ~rst;
  assign STALL_CNT  = stall_cnt_q;

endmodule
